// File: rtl/nibble_descrambler.sv
// nibble_descrambler: XORs each accepted 4-bit nibble with a keystream
// nibble taken from a 4-bit Fibonacci LFSR (x^4+x^3+1). The keystream
// restarts from the stored seed at every block boundary of BLOCK_LEN nibbles.
//
// Handshake: a transfer happens on a rising edge when both valid and ready
// are high on that port. Once out_valid is raised, out_data holds stable
// until out_ready is high. in_ready never depends on in_valid.
module nibble_descrambler #(
  parameter int unsigned BLOCK_LEN = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       seed_load,
  input  logic [3:0] seed,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [3:0] out_data,
  input  logic       out_ready,
  output logic [7:0] blk_count,
  output logic       blk_done,
  output logic       state_dbg
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(BLOCK_LEN - 1);

  state_t     state;
  logic [3:0] s;          // current keystream nibble (LFSR state)
  logic [3:0] seed_q;     // seed kept for block restarts
  logic [3:0] seed_fixed; // seed with the all-zero lock-up value remapped
  logic [3:0] s_next;
  logic       xfer;
  logic       last;

  // A zero seed would freeze the LFSR, so it loads as 1.
  assign seed_fixed = (seed == 4'h0) ? 4'h1 : seed;
  assign s_next     = {s[2:0], s[3] ^ s[2]};

  // Input is taken only in RUN, never in a seed_load cycle, and only when
  // the output register is empty or being drained this cycle.
  assign in_ready = (state == RUN) && !seed_load && (!out_valid || out_ready);
  assign xfer     = in_valid && in_ready;
  assign last     = (blk_count == LAST_IDX);

  assign state_dbg = state;

  // State machine, keystream, block counter and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s         <= 4'h1;
      seed_q    <= 4'h1;
      blk_count <= 8'd0;
      out_valid <= 1'b0;
      out_data  <= 4'h0;
      blk_done  <= 1'b0;
    end else begin
      blk_done <= 1'b0;
      if (seed_load) begin
        // Restart wins over everything; a pending output is dropped.
        state     <= RUN;
        s         <= seed_fixed;
        seed_q    <= seed_fixed;
        blk_count <= 8'd0;
        out_valid <= 1'b0;
      end else if (xfer) begin
        out_data  <= in_data ^ s;
        out_valid <= 1'b1;
        if (last) begin
          // Next block starts again from the stored seed.
          blk_count <= 8'd0;
          s         <= seed_q;
          blk_done  <= 1'b1;
        end else begin
          blk_count <= blk_count + 8'd1;
          s         <= s_next;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nibble_descrambler.sv
// Bench for nibble_descrambler: two instances (default block length and a
// block length of 2) share one stimulus stream and are compared each cycle
// against a block-position based reference model.
module tb_nibble_descrambler;

  localparam int BL0 = 16;
  localparam int BL1 = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       seed_load = 1'b0;
  logic [3:0] seed = 4'h0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'h0;
  logic       out_ready = 1'b0;

  logic       ir0, ov0, bd0, st0;
  logic [3:0] od0;
  logic [7:0] bc0;
  logic       ir1, ov1, bd1, st1;
  logic [3:0] od1;
  logic [7:0] bc1;

  nibble_descrambler #(.BLOCK_LEN(BL0)) dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir0),
    .out_valid(ov0), .out_data(od0), .out_ready(out_ready),
    .blk_count(bc0), .blk_done(bd0), .state_dbg(st0)
  );

  nibble_descrambler #(.BLOCK_LEN(BL1)) dut2 (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir1),
    .out_valid(ov1), .out_data(od1), .out_ready(out_ready),
    .blk_count(bc1), .blk_done(bd1), .state_dbg(st1)
  );

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [3:0] exp_q[$];

  int         bl[2] = '{BL0, BL1};
  bit         m_run;
  logic [3:0] m_seed;
  int         m_pos[2];
  bit         m_ov;
  logic [3:0] m_od[2];
  bit         m_done[2];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Keystream nibble at position n of a block: the seed stepped n times.
  function automatic logic [3:0] ks(input logic [3:0] sd, input int n);
    logic [3:0] v;
    v = sd;
    repeat (n) v = {v[2:0], v[3] ^ v[2]};
    return v;
  endfunction

  task automatic model_reset();
    m_run  = 1'b0;
    m_seed = 4'h1;
    m_ov   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_pos[i]  = 0;
      m_od[i]   = 4'h0;
      m_done[i] = 1'b0;
    end
    exp_q.delete();
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid0"}, 8'(ov0), 8'(m_ov));
    check({tag, ".out_valid1"}, 8'(ov1), 8'(m_ov));
    check({tag, ".out_data0"}, 8'(od0), 8'(m_od[0]));
    check({tag, ".out_data1"}, 8'(od1), 8'(m_od[1]));
    check({tag, ".blk_count0"}, bc0, 8'(m_pos[0]));
    check({tag, ".blk_count1"}, bc1, 8'(m_pos[1]));
    check({tag, ".blk_done0"}, 8'(bd0), 8'(m_done[0]));
    check({tag, ".blk_done1"}, 8'(bd1), 8'(m_done[1]));
    check({tag, ".state0"}, 8'(st0), 8'(m_run));
    check({tag, ".state1"}, 8'(st1), 8'(m_run));
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle: inputs applied just after a falling edge, in_ready
  // checked before the rising edge, registered outputs checked after it.
  task automatic cycle(input string tag, input bit sl, input logic [3:0] sd,
                       input bit iv, input logic [3:0] id, input bit ordy);
    bit exp_rdy;
    seed_load = sl;
    seed      = sd;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    exp_rdy = m_run && !sl && (!m_ov || ordy);
    check({tag, ".in_ready0"}, 8'(ir0), 8'(exp_rdy));
    check({tag, ".in_ready1"}, 8'(ir1), 8'(exp_rdy));
    if (ov0 && ordy) begin
      if (exp_q.size() == 0) check({tag, ".unexpected_out"}, 8'(ov0), 8'd0);
      else check({tag, ".sb_data"}, 8'(od0), 8'(exp_q.pop_front()));
    end
    if (sl) begin
      m_run  = 1'b1;
      m_seed = (sd == 4'h0) ? 4'h1 : sd;
      m_ov   = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_pos[i]  = 0;
        m_done[i] = 1'b0;
      end
      exp_q.delete();
    end else if (iv && exp_rdy) begin
      for (int i = 0; i < 2; i++) begin
        m_od[i]   = id ^ ks(m_seed, m_pos[i]);
        m_done[i] = (m_pos[i] == bl[i] - 1);
        m_pos[i]  = (m_pos[i] + 1) % bl[i];
      end
      m_ov = 1'b1;
      exp_q.push_back(m_od[0]);
    end else begin
      if (ordy) m_ov = 1'b0;
      for (int i = 0; i < 2; i++) m_done[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  // Reset pulse in the middle of a cycle; outputs must clear at once.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    check({tag, ".in_ready0"}, 8'(ir0), 8'd0);
    check({tag, ".in_ready1"}, 8'(ir1), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs("reset");
    check("reset.in_ready0", 8'(ir0), 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Input in IDLE is ignored.
    cycle("idle", 1'b0, 4'h0, 1'b1, 4'h5, 1'b1);

    // Seed 9, inputs F,0,0 -> 6,3,6.
    cycle("r028.seed", 1'b1, 4'h9, 1'b0, 4'h0, 1'b1);
    cycle("r028.a", 1'b0, 4'h0, 1'b1, 4'hF, 1'b1);
    check("r028.lit0", 8'(od0), 8'h06);
    cycle("r028.b", 1'b0, 4'h0, 1'b1, 4'h0, 1'b1);
    check("r028.lit1", 8'(od0), 8'h03);
    cycle("r028.c", 1'b0, 4'h0, 1'b1, 4'h0, 1'b1);
    check("r028.lit2", 8'(od0), 8'h06);
    cycle("r028.drain", 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);

    // Zero seed loads as 1.
    cycle("r029.seed", 1'b1, 4'h0, 1'b0, 4'h0, 1'b1);
    cycle("r029.a", 1'b0, 4'h0, 1'b1, 4'h0, 1'b1);
    check("r029.lit", 8'(od0), 8'h01);

    // Block length 2 on the second instance.
    cycle("r030.seed", 1'b1, 4'h9, 1'b0, 4'h0, 1'b1);
    begin
      logic [3:0] exp_o[4] = '{4'h9, 4'h3, 4'h9, 4'h3};
      bit         exp_d[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [7:0] exp_c[4] = '{8'd0, 8'd1, 8'd0, 8'd1};
      for (int k = 0; k < 4; k++) begin
        check("r030.count", bc1, exp_c[k]);
        cycle("r030.x", 1'b0, 4'h0, 1'b1, 4'h0, 1'b1);
        check("r030.out", 8'(od1), 8'(exp_o[k]));
        check("r030.done", 8'(bd1), 8'(exp_d[k]));
      end
    end

    // Back-pressure for 3 cycles.
    cycle("r031.seed", 1'b1, 4'h5, 1'b0, 4'h0, 1'b1);
    cycle("r031.a", 1'b0, 4'h0, 1'b1, 4'h1, 1'b1);
    for (int k = 0; k < 3; k++) cycle("r031.stall", 1'b0, 4'h0, 1'b1, 4'hA, 1'b0);
    cycle("r031.b", 1'b0, 4'h0, 1'b1, 4'hA, 1'b1);
    cycle("r031.c", 1'b0, 4'h0, 1'b1, 4'h2, 1'b1);
    cycle("r031.drain", 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);

    // seed_load with in_valid while an output is pending.
    cycle("r032.seed", 1'b1, 4'h3, 1'b0, 4'h0, 1'b1);
    cycle("r032.a", 1'b0, 4'h0, 1'b1, 4'h4, 1'b0);
    cycle("r032.reseed", 1'b1, 4'hC, 1'b1, 4'h7, 1'b0);
    check("r032.valid", 8'(ov0), 8'd0);
    cycle("r032.b", 1'b0, 4'h0, 1'b1, 4'h0, 1'b1);
    check("r032.lit", 8'(od0), 8'h0C);

    // Reset mid-stream.
    cycle("r033.seed", 1'b1, 4'h6, 1'b0, 4'h0, 1'b1);
    cycle("r033.a", 1'b0, 4'h0, 1'b1, 4'h3, 1'b0);
    do_reset("r033.rst");
    cycle("r033.ign", 1'b0, 4'h0, 1'b1, 4'h9, 1'b1);
    cycle("r033.ign2", 1'b0, 4'h0, 1'b1, 4'h9, 1'b1);
    cycle("r033.seed2", 1'b1, 4'h6, 1'b0, 4'h0, 1'b1);
    cycle("r033.b", 1'b0, 4'h0, 1'b1, 4'h3, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 999) < 3) begin
        do_reset("rnd.rst");
      end else begin
        cycle("rnd", $urandom_range(0, 99) < 3, 4'($urandom_range(0, 15)),
              $urandom_range(0, 99) < 70, 4'($urandom_range(0, 15)),
              $urandom_range(0, 99) < 75);
      end
    end

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_descrambler.md
NIBBLE_DESCRAMBLER -- requirements
Module: nibble_descrambler

Interface
REQ-001 The block SHALL have one parameter: BLOCK_LEN, default 16, giving the number of nibbles per keystream block (legal range 2..255).
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port seed_load, input, 1 bit: one-cycle request to load the seed and start or restart a stream.
REQ-006 Port seed, input, 4 bits: the keystream seed, sampled when seed_load=1.
REQ-007 Port in_valid, input, 1 bit: scrambled nibble present on in_data.
REQ-008 Port in_data, input, 4 bits: scrambled nibble.
REQ-009 Port in_ready, output, 1 bit: block accepts in_data this cycle.
REQ-010 Port out_valid, output, 1 bit: descrambled nibble held on out_data.
REQ-011 Port out_data, output, 4 bits: descrambled nibble (bitwise XOR of the input nibble and the keystream).
REQ-012 Port out_ready, input, 1 bit: downstream accepts out_data.
REQ-013 Port blk_count, output, 8 bits: number of nibbles accepted in the current block.
REQ-014 Port blk_done, output, 1 bit: one-cycle pulse when a block completes.

Function
REQ-015 The state machine SHALL have two states: IDLE (no seed loaded) and RUN; seed_load=1 SHALL move the block to RUN from either state.
REQ-016 The keystream SHALL be a 4-bit Fibonacci LFSR, polynomial x^4+x^3+1: next = {s[2:0], s[3]^s[2]}; the current keystream nibble is s.
REQ-017 A seed of 4'h0 SHALL load as 4'h1, so the LFSR never locks up; any other seed loads unchanged.
REQ-018 in_ready SHALL equal (state==RUN) AND NOT seed_load AND (NOT out_valid OR out_ready).
REQ-019 On a transfer (in_valid AND in_ready), on the same edge:
- out_data <= in_data ^ s
- out_valid <= 1
- s advances one step
- blk_count increments
REQ-020 Latency from input transfer to out_valid SHALL be 1 cycle; full throughput is 1 nibble per cycle while out_ready=1.
REQ-021 out_valid SHALL clear when out_ready=1 and there is no new transfer that cycle; out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 When a transfer occurs with blk_count==BLOCK_LEN-1:
- blk_count <= 0
- s <= the stored seed, not the advanced value
- blk_done pulses high in the next cycle, aligned with that block's last out_valid
REQ-023 seed_load SHALL have priority over everything else:
- s <= seed (zero-fixed), and the seed is stored for block restarts
- blk_count <= 0
- out_valid <= 0; any pending output is discarded
- no input transfer occurs that cycle
REQ-024 In IDLE, in_ready SHALL be 0 and input SHALL be ignored.
REQ-025 in_valid with in_ready=0 SHALL cause no state change.

Reset
REQ-026 rst_n=0 SHALL immediately force:
- state IDLE
- s = 4'h1 and stored seed = 4'h1
- blk_count = 0
- out_valid = 0, out_data = 4'h0
- blk_done = 0
- in_ready = 0
REQ-027 Reset asserted mid-stream SHALL discard all data in flight; after release, a new seed_load is required before any input is accepted.

Verification
REQ-028 Seed 4'h9, then inputs 4'hF, 4'h0, 4'h0 with out_ready=1 -> out_data 4'h6, 4'h3, 4'h6 on consecutive cycles, each 1 cycle after its input.
REQ-029 Seed 4'h0, then input 4'h0 -> out_data 4'h1 (zero-seed fix).
REQ-030 BLOCK_LEN=2, seed 4'h9, four inputs of 4'h0 -> outputs 4'h9, 4'h3, 4'h9, 4'h3; blk_done pulses with the 2nd and 4th outputs; blk_count reads 0,1,0,1 across the transfers.
REQ-031 out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, out_data stable, no LFSR advance; after release, the stream resumes with no loss or duplication.
REQ-032 seed_load asserted together with in_valid while out_valid=1 -> input not accepted, out_valid=0 next cycle, next accepted nibble is XORed with the new seed.
REQ-033 rst_n pulsed low mid-stream -> outputs take their reset values at once; in_valid is ignored until a new seed_load.
